// File: rtl/ibex_data_mem_bridge_if.sv
// Bus interfaces for the data-side bridge: the LSU req/gnt/rvalid port and
// the in-order, variable-latency memory port.

// LSU data port. The master is the load/store unit; the slave is the bridge.
interface ibex_data_if;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        bus_err;

    modport master (output req, addr, we, be, wdata,
                    input  gnt, rvalid, rdata, bus_err);
    modport slave  (input  req, addr, we, be, wdata,
                    output gnt, rvalid, rdata, bus_err);
endinterface

// Memory port. The master is the bridge; the slave is the memory.
// AW is the word-index width, log2(region bytes) - 2.
interface ibex_mem_if #(parameter int AW = 14);
    logic          req;
    logic          gnt;
    logic          we;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic          rvalid;
    logic [31:0]   rdata;
    logic          err;

    modport master (output req, we, addr, be, wdata,
                    input  gnt, rvalid, rdata, err);
    modport slave  (input  req, we, addr, be, wdata,
                    output gnt, rvalid, rdata, err);
endinterface

// File: rtl/ibex_data_mem_bridge.sv
// Data-side bridge between the LSU and an in-order memory port.
// Illegal accesses (out of range, ROM store, empty byte mask) are granted
// locally and answered with a bus error; legal ones go to memory. A small
// FIFO of 1-bit tags (1 = local error, 0 = memory) keeps responses in order.
module ibex_data_mem_bridge #(
    parameter logic [31:0] AddrBase       = 32'h0010_0000,
    parameter logic [31:0] MemBytes       = 32'h0001_0000,
    parameter logic [31:0] RomBytes       = 32'h0000_1000,
    parameter int          MaxOutstanding = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    ibex_data_if.slave    data,
    ibex_mem_if.master    mem,
    output logic [2:0]    outstanding_o,
    output logic          proto_err_o
);
    localparam int              AW      = $clog2(MemBytes) - 2;
    localparam int              PW      = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [PW-1:0]   LastPtr = PW'(MaxOutstanding - 1);
    localparam logic [2:0]      MaxCnt  = 3'(MaxOutstanding);

    // Range bounds on 33 bits so an address near 32'hFFFF_FFFC cannot wrap.
    localparam logic [32:0] LoX  = {1'b0, AddrBase};
    localparam logic [32:0] HiX  = {1'b0, AddrBase} + {1'b0, MemBytes};
    localparam logic [32:0] RomX = {1'b0, AddrBase} + {1'b0, RomBytes};

    logic [MaxOutstanding-1:0] fifo_q;
    logic [PW-1:0]             wptr_q, wptr_d;
    logic [PW-1:0]             rptr_q, rptr_d;
    logic [2:0]                count_q, count_d;
    logic                      proto_err_q, proto_err_d;

    logic [32:0] addr_x;
    logic        in_range, in_rom, req_err;
    logic        full, empty, head;
    logic        push, pop, proto_viol;

    assign addr_x   = {1'b0, data.addr};
    assign in_range = (addr_x >= LoX) && (addr_x < HiX);
    assign in_rom   = (addr_x < RomX);
    assign req_err  = ~in_range | (data.we & in_rom) | (data.be == 4'b0000);

    // Occupancy comes from the registered count only: a pop this cycle does
    // not open a slot until the next cycle, keeping gnt off the rvalid path.
    assign full  = (count_q == MaxCnt);
    assign empty = (count_q == 3'd0);
    assign head  = fifo_q[rptr_q];

    assign mem.req   = data.req & ~req_err & ~full;
    assign mem.we    = data.we;
    assign mem.addr  = data.addr[AW+1:2] - AddrBase[AW+1:2];
    assign mem.be    = data.be;
    assign mem.wdata = data.wdata;

    assign data.gnt  = data.req & ~full & (req_err | mem.gnt);

    assign push       = data.gnt;
    assign pop        = ~empty & (head | mem.rvalid);
    assign proto_viol = mem.rvalid & (empty | head);

    assign data.rvalid  = pop;
    assign data.bus_err = pop & (head | mem.err);
    assign data.rdata   = (pop & ~head) ? mem.rdata : 32'h0;

    assign outstanding_o = count_q;
    assign proto_err_o   = proto_err_q;

    // Next-state for tracker pointers, occupancy and the sticky protocol flag.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        proto_err_d = proto_err_q | proto_viol;
        if (push) wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + PW'(1);
        if (pop)  rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + PW'(1);
        count_d = count_q + {2'b00, push} - {2'b00, pop};
    end

    // Tracker state; FIFO contents are left untouched by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= 3'd0;
            proto_err_q <= 1'b0;
        end else begin
            if (push) fifo_q[wptr_q] <= req_err;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            proto_err_q <= proto_err_d;
        end
    end
endmodule

// File: tb/tb_ibex_data_mem_bridge.sv
// Directed bench for ibex_data_mem_bridge. The stimulus thread pushes the
// expected response of every granted request into a scoreboard; a monitor
// pops and compares whenever the bridge presents data_rvalid.
module tb_ibex_data_mem_bridge;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] outstanding;
    logic       proto_err;

    always #5 clk = ~clk;

    ibex_data_if              dbus ();
    ibex_mem_if #(.AW(14))    mbus ();

    ibex_data_mem_bridge dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .data          (dbus),
        .mem           (mbus),
        .outstanding_o (outstanding),
        .proto_err_o   (proto_err)
    );

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One LSU request expected to be granted in its first cycle.
    task automatic lsu_req(input logic [31:0] a, input logic we, input logic [3:0] be,
                           input logic [31:0] wd, input logic exp_mreq,
                           input logic [13:0] exp_maddr, input exp_t e);
        dbus.req = 1'b1; dbus.addr = a; dbus.we = we; dbus.be = be; dbus.wdata = wd;
        @(negedge clk);
        check("gnt", {31'h0, dbus.gnt}, 32'h1);
        check("mem_req", {31'h0, mbus.req}, {31'h0, exp_mreq});
        if (exp_mreq) check("mem_addr", {18'h0, mbus.addr}, {18'h0, exp_maddr});
        if (dbus.gnt) sb.push_back(e);
        cyc();
        dbus.req = 1'b0; dbus.we = 1'b0; dbus.be = 4'h0;
    endtask

    // One-cycle memory response; the bridge must forward it in the same cycle.
    task automatic mem_resp(input logic [31:0] rd, input logic err);
        mbus.rvalid = 1'b1; mbus.rdata = rd; mbus.err = err;
        @(negedge clk);
        check("fwd_rvalid", {31'h0, dbus.rvalid}, 32'h1);
        cyc();
        mbus.rvalid = 1'b0; mbus.rdata = 32'h0; mbus.err = 1'b0;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (dbus.rvalid) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_rvalid: got rvalid=1 err=%b rdata=%h, expected no response",
                             dbus.bus_err, dbus.rdata);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_err", {31'h0, dbus.bus_err}, {31'h0, e.err});
                    check("rsp_rdata", dbus.rdata, e.rdata);
                end
            end else begin
                check("idle_rdata", dbus.rdata, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        dbus.req = 0; dbus.addr = 0; dbus.we = 0; dbus.be = 0; dbus.wdata = 0;
        mbus.gnt = 1; mbus.rvalid = 0; mbus.rdata = 0; mbus.err = 0;

        // Reset state
        cyc(); cyc();
        @(negedge clk);
        check("rst_outstanding", {29'h0, outstanding}, 32'h0);
        check("rst_rvalid", {31'h0, dbus.rvalid}, 32'h0);
        check("rst_proto", {31'h0, proto_err}, 32'h0);
        check("rst_rdata", dbus.rdata, 32'h0);
        cyc();
        rst = 1'b0;

        // Legal load: grant c0, response c2
        lsu_req(32'h0010_2000, 1'b0, 4'hF, 32'h0, 1'b1, 14'h0800, '{1'b0, 32'hDEAD_BEEF});
        @(negedge clk);
        check("ld_outstanding1", {29'h0, outstanding}, 32'h1);
        check("ld_no_early_rvalid", {31'h0, dbus.rvalid}, 32'h0);
        cyc();
        mem_resp(32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        check("ld_outstanding0", {29'h0, outstanding}, 32'h0);
        cyc();

        // ROM store: local error the next cycle
        lsu_req(32'h0010_0010, 1'b1, 4'hF, 32'hCAFE_F00D, 1'b0, 14'h0, '{1'b1, 32'h0});
        @(negedge clk);
        check("rom_rvalid", {31'h0, dbus.rvalid}, 32'h1);
        check("rom_bus_err", {31'h0, dbus.bus_err}, 32'h1);
        cyc();

        // Ordering: error behind a delayed memory load
        lsu_req(32'h0010_0004, 1'b0, 4'hF, 32'h0, 1'b1, 14'h0001, '{1'b0, 32'h1111_2222});
        lsu_req(32'h0000_0000, 1'b0, 4'hF, 32'h0, 1'b0, 14'h0, '{1'b1, 32'h0});
        @(negedge clk);
        check("ord_hold_c2", {31'h0, dbus.rvalid}, 32'h0);
        cyc();
        mem_resp(32'h1111_2222, 1'b0);
        @(negedge clk);
        check("ord_err_rvalid", {31'h0, dbus.rvalid}, 32'h1);
        check("ord_err_bus_err", {31'h0, dbus.bus_err}, 32'h1);
        cyc();
        @(negedge clk);
        check("ord_outstanding0", {29'h0, outstanding}, 32'h0);
        cyc();

        // Full: third request held until the cycle after the first pop
        lsu_req(32'h0010_0100, 1'b0, 4'hF, 32'h0, 1'b1, 14'h0040, '{1'b0, 32'h0000_B0B0});
        lsu_req(32'h0010_0200, 1'b0, 4'hF, 32'h0, 1'b1, 14'h0080, '{1'b0, 32'h0000_C0C0});
        dbus.req = 1'b1; dbus.addr = 32'h0010_0300; dbus.we = 1'b0; dbus.be = 4'hF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("full_outstanding", {29'h0, outstanding}, 32'h2);
            check("full_gnt", {31'h0, dbus.gnt}, 32'h0);
            check("full_mem_req", {31'h0, mbus.req}, 32'h0);
            cyc();
        end
        mbus.rvalid = 1'b1; mbus.rdata = 32'h0000_B0B0;
        @(negedge clk);
        check("full_gnt_on_pop", {31'h0, dbus.gnt}, 32'h0);
        check("full_pop_rvalid", {31'h0, dbus.rvalid}, 32'h1);
        cyc();
        mbus.rvalid = 1'b0; mbus.rdata = 32'h0;
        @(negedge clk);
        check("full_gnt_after_pop", {31'h0, dbus.gnt}, 32'h1);
        check("full_mem_addr", {18'h0, mbus.addr}, 32'h00C0);
        if (dbus.gnt) sb.push_back('{1'b0, 32'h0000_D0D0});
        cyc();
        dbus.req = 1'b0; dbus.be = 4'h0;
        mem_resp(32'h0000_C0C0, 1'b0);
        mem_resp(32'h0000_D0D0, 1'b0);
        @(negedge clk);
        check("full_drained", {29'h0, outstanding}, 32'h0);
        cyc();

        // Protocol violation, then a memory error response
        mbus.rvalid = 1'b1; mbus.rdata = 32'h5555_5555;
        @(negedge clk);
        check("proto_no_rvalid", {31'h0, dbus.rvalid}, 32'h0);
        cyc();
        mbus.rvalid = 1'b0; mbus.rdata = 32'h0;
        @(negedge clk);
        check("proto_set", {31'h0, proto_err}, 32'h1);
        cyc();
        @(negedge clk);
        check("proto_sticky", {31'h0, proto_err}, 32'h1);
        cyc();
        lsu_req(32'h0010_0008, 1'b0, 4'hF, 32'h0, 1'b1, 14'h0002, '{1'b1, 32'h0BAD_0BAD});
        mem_resp(32'h0BAD_0BAD, 1'b1);
        @(negedge clk);
        check("proto_still_set", {31'h0, proto_err}, 32'h1);
        cyc();

        // Memory stall: no grant while mem_gnt low
        mbus.gnt = 1'b0;
        dbus.req = 1'b1; dbus.addr = 32'h0010_0000; dbus.we = 1'b0; dbus.be = 4'hF;
        @(negedge clk);
        check("stall_gnt", {31'h0, dbus.gnt}, 32'h0);
        check("stall_mem_req", {31'h0, mbus.req}, 32'h1);
        cyc();
        mbus.gnt = 1'b1;
        lsu_req(32'h0010_0000, 1'b0, 4'hF, 32'h0, 1'b1, 14'h0000, '{1'b0, 32'hA5A5_0001});
        mem_resp(32'hA5A5_0001, 1'b0);

        // Boundaries
        lsu_req(32'h0010_FFFC, 1'b0, 4'hF, 32'h0, 1'b1, 14'h3FFF, '{1'b0, 32'h1234_5678});
        mem_resp(32'h1234_5678, 1'b0);
        lsu_req(32'h0011_0000, 1'b0, 4'hF, 32'h0, 1'b0, 14'h0, '{1'b1, 32'h0});
        lsu_req(32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0, 1'b0, 14'h0, '{1'b1, 32'h0});
        lsu_req(32'h0010_0008, 1'b0, 4'h0, 32'h0, 1'b0, 14'h0, '{1'b1, 32'h0});
        lsu_req(32'h0010_0FFC, 1'b1, 4'hF, 32'h1, 1'b0, 14'h0, '{1'b1, 32'h0});
        lsu_req(32'h0010_1000, 1'b1, 4'h3, 32'h2, 1'b1, 14'h0400, '{1'b0, 32'h0});
        mem_resp(32'h0, 1'b0);
        @(negedge clk);
        check("bnd_drained", {29'h0, outstanding}, 32'h0);
        cyc();

        // Reset with two outstanding
        lsu_req(32'h0010_0020, 1'b0, 4'hF, 32'h0, 1'b1, 14'h0008, '{1'b0, 32'h0});
        lsu_req(32'h0010_0024, 1'b0, 4'hF, 32'h0, 1'b1, 14'h0009, '{1'b0, 32'h0});
        @(negedge clk);
        check("pre_rst_outstanding", {29'h0, outstanding}, 32'h2);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("post_rst_outstanding", {29'h0, outstanding}, 32'h0);
        check("post_rst_rvalid", {31'h0, dbus.rvalid}, 32'h0);
        check("post_rst_proto", {31'h0, proto_err}, 32'h0);
        cyc();
        mbus.rvalid = 1'b1; mbus.rdata = 32'h0000_0020;
        cyc();
        mbus.rvalid = 1'b0; mbus.rdata = 32'h0;
        @(negedge clk);
        check("late_rsp_proto", {31'h0, proto_err}, 32'h1);
        cyc(); cyc();

        check("sb_empty", sb.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
